// File: rtl/bus_ram_responder.sv
// Single-port word RAM on the simple bus: one registered o_ack per request, WAIT_STATES+1 cycles after it is seen in IDLE.
// Initiator holds i_bus_en until ack and must drop it for a cycle before the next request; optional o_err via ARVI_BUS_RAM_ERR_EN.
module bus_ram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data
`ifdef ARVI_BUS_RAM_ERR_EN
  ,
  output logic        o_err
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  localparam logic [32:0] OFF_LIMIT = 33'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        ack_q;
  logic [31:0] rd_data_q;

  logic [31:0] mem [DEPTH];

  logic          ack_entry;
  logic          op_from_inputs;
  logic [31:0]   op_addr;
  logic          op_wr;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;
  logic [31:0]   op_off;
  logic [AW-1:0] op_idx;
  logic          op_in_range;
  logic          op_err;
  logic          do_write;
  logic          do_read;

`ifdef ARVI_BUS_RAM_ERR_EN
  logic err_q;

  function automatic logic be_noncontig(input logic [3:0] be);
    logic r;
    r = 1'b0;
    case (be)
      4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1101: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (i_bus_en) begin
          addr_d  = i_addr;
          wr_d    = i_wr_en;
          wdata_d = i_wr_data;
          be_d    = i_byte_en;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (!i_bus_en) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // With zero wait states the RAM access happens on the capture edge, so it must use the live inputs.
  always_comb begin
    ack_entry      = (state_d == S_ACK);
    op_from_inputs = (state_q == S_IDLE);
    op_addr        = op_from_inputs ? i_addr    : addr_q;
    op_wr          = op_from_inputs ? i_wr_en   : wr_q;
    op_wdata       = op_from_inputs ? i_wr_data : wdata_q;
    op_be          = op_from_inputs ? i_byte_en : be_q;
    op_off         = op_addr - BASE_ADDR;
    op_idx         = op_off[AW+1:2];
    op_in_range    = ({1'b0, op_off} < OFF_LIMIT);
`ifdef ARVI_BUS_RAM_ERR_EN
    op_err         = !op_in_range || (op_wr && be_noncontig(op_be));
`else
    op_err         = !op_in_range;
`endif
    do_write       = ack_entry && op_wr && !op_err && i_rst;
    do_read        = ack_entry && !op_wr;
  end

  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) begin
          mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      ack_q     <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_entry;
      if (do_read) begin
        rd_data_q <= op_err ? 32'd0 : mem[op_idx];
      end
    end
  end

`ifdef ARVI_BUS_RAM_ERR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ack_entry && op_err;
    end
  end

  assign o_err = err_q;
`endif

  assign o_ack     = ack_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench: u0 has zero wait states at base 0, u3 has three wait states, 64 words at base 0x1000.
module tb_bus_ram_responder;

  logic clk;
  logic rst_n;
  logic        bus_en [2];
  logic        wr_en  [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  be     [2];
  logic        ack    [2];
  logic [31:0] rd     [2];
`ifdef ARVI_BUS_RAM_ERR_EN
  logic        err    [2];
  logic        last_err;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_ram_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u0 (
    .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]),
    .i_addr(addr[0]), .i_wr_data(wdata[0]), .i_byte_en(be[0]),
    .o_ack(ack[0]), .o_rd_data(rd[0])
`ifdef ARVI_BUS_RAM_ERR_EN
    , .o_err(err[0])
`endif
  );

  bus_ram_responder #(.DEPTH(64), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u3 (
    .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]),
    .i_addr(addr[1]), .i_wr_data(wdata[1]), .i_byte_en(be[1]),
    .o_ack(ack[1]), .o_rd_data(rd[1])
`ifdef ARVI_BUS_RAM_ERR_EN
    , .o_err(err[1])
`endif
  );

  // Drives one request, scrambles the data inputs once captured, returns latency (-1 on timeout).
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output int lat, output logic [31:0] rdat);
    @(negedge clk);
    bus_en[d] = 1'b1; wr_en[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    lat = -1;
    rdat = 32'hxxxx_xxxx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack[d] === 1'b1) begin
        lat = i;
        rdat = rd[d];
`ifdef ARVI_BUS_RAM_ERR_EN
        last_err = err[d];
`endif
        break;
      end
      addr[d] = ~a; wdata[d] = ~wd; be[d] = ~b;
    end
    bus_en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; be[d] = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      bus_en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; be[d] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]); end
      checks++;
      if (rd[d] !== 32'd0) begin errors++; $display("FAIL reset_rd[%0d]: got %h expected 0", d, rd[d]); end
`ifdef ARVI_BUS_RAM_ERR_EN
      checks++;
      if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic [31:0] r;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, r);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL basic_wr_lat: got %0d expected 1", lat); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, r);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL basic_rd_lat: got %0d expected 1", lat); end
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", r); end
  endtask

  task automatic test_byte_lanes;
    int lat;
    logic [31:0] r;
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, r);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, r);
    checks++;
    if (r !== 32'h11223344) begin errors++; $display("FAIL lanes_init: got %h expected 11223344", r); end
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0010, lat, r);
    checks++;
    if (r !== 32'h11223344) begin errors++; $display("FAIL lanes_rd_hold_on_wr: got %h expected 11223344", r); end
`ifdef ARVI_BUS_RAM_ERR_EN
    checks++;
    if (last_err !== 1'b0) begin errors++; $display("FAIL lanes_contig_err: got %b expected 0", last_err); end
`endif
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h1122CC44) begin errors++; $display("FAIL lanes_one_byte: got %h expected 1122cc44", r); end
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, r);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL lanes_noop_lat: got %0d expected 1", lat); end
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h1122CC44) begin errors++; $display("FAIL lanes_noop: got %h expected 1122cc44", r); end
    txn(0, 1'b1, 32'h20, 32'h55667788, 4'b0101, lat, r);
`ifdef ARVI_BUS_RAM_ERR_EN
    checks++;
    if (last_err !== 1'b1) begin errors++; $display("FAIL lanes_noncontig_err: got %b expected 1", last_err); end
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h1122CC44) begin errors++; $display("FAIL lanes_noncontig: got %h expected 1122cc44", r); end
`else
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h1166CC88) begin errors++; $display("FAIL lanes_noncontig: got %h expected 1166cc88", r); end
`endif
  endtask

  task automatic test_wait_states;
    int lat;
    logic [31:0] r;
    int start_cyc;
    txn(1, 1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, lat, r);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL ws_wr_lat: got %0d expected 4", lat); end
    @(negedge clk);
    bus_en[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 32'h1010; be[1] = 4'h0;
    start_cyc = 10;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (ack[1] !== (i == 4)) begin
        errors++;
        $display("FAIL ws_ack_cycle%0d: got %b expected %b", start_cyc + i, ack[1], (i == 4));
      end
      if (i == 1) addr[1] = 32'h1FFC;
      if (i == 4) begin
        checks++;
        if (rd[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rd_data: got %h expected cafef00d", rd[1]); end
        bus_en[1] = 1'b0;
      end
    end
  endtask

  task automatic test_hold;
    int lat;
    @(negedge clk);
    bus_en[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = 32'h10;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL hold_first_lat: got %0d expected 1", lat); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (ack[0] !== 1'b0) begin errors++; $display("FAIL hold_no_reack%0d: got %b expected 0", i, ack[0]); end
    end
    bus_en[0] = 1'b0;
    @(negedge clk);
    bus_en[0] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL hold_rereq_lat: got %0d expected 1", lat); end
    checks++;
    if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rereq_data: got %h expected deadbeef", rd[0]); end
    bus_en[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range;
    int lat;
    logic [31:0] r;
    txn(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, lat, r);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, r);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, lat, r);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL oor_rd_lat: got %0d expected 1", lat); end
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", r); end
`ifdef ARVI_BUS_RAM_ERR_EN
    checks++;
    if (last_err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", last_err); end
`endif
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, lat, r);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL oor_wr_lat: got %0d expected 1", lat); end
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'hA5A5A5A5) begin errors++; $display("FAIL oor_wr_word0: got %h expected a5a5a5a5", r); end
    txn(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, lat, r);
    checks++;
    if (lat != 4 || r !== 32'h0) begin errors++; $display("FAIL oor_below_base: got lat %0d data %h expected lat 4 data 0", lat, r); end
    txn(1, 1'b1, 32'h1000, 32'h0BADCAFE, 4'hF, lat, r);
    txn(1, 1'b1, 32'h10FC, 32'h600DF00D, 4'hF, lat, r);
    txn(1, 1'b1, 32'h1100, 32'hFFFFFFFF, 4'hF, lat, r);
    txn(1, 1'b0, 32'h1000, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h0BADCAFE) begin errors++; $display("FAIL oor_above_base_word0: got %h expected 0badcafe", r); end
    txn(1, 1'b0, 32'h10FC, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h600DF00D) begin errors++; $display("FAIL top_word: got %h expected 600df00d", r); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [31:0] r;
    txn(1, 1'b1, 32'h1030, 32'h01020304, 4'hF, lat, r);
    txn(1, 1'b0, 32'h1030, 32'h0, 4'hF, lat, r);
    checks++;
    if (r !== 32'h01020304) begin errors++; $display("FAIL rstmid_pre: got %h expected 01020304", r); end
    @(negedge clk);
    bus_en[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 32'h1030; wdata[1] = 32'hFFFFFFFF; be[1] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_en[1] = 1'b0; wr_en[1] = 1'b0;
    checks++;
    if (rd[1] !== 32'h0 || rd[0] !== 32'h0) begin errors++; $display("FAIL rstmid_rd: got %h/%h expected 0/0", rd[1], rd[0]); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ack[1] !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack%0d: got %b expected 0", i, ack[1]); end
      @(negedge clk);
    end
    txn(1, 1'b0, 32'h1030, 32'h0, 4'hF, lat, r);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL rstmid_next_lat: got %0d expected 4", lat); end
    checks++;
    if (r !== 32'h01020304) begin errors++; $display("FAIL rstmid_word: got %h expected 01020304", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_hold();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_ram_responder.md
Name: bus_ram_responder

Overview:
- Responder (slave) end of the core's simple single-master bus. Serves word reads and byte-enabled writes from an internal 32-bit-wide RAM.
- Each transaction gets exactly one `o_ack` pulse, after a programmable number of wait states.
- Sits on the bus opposite the datapath bus converter and stands in for instruction/data memory in simulation and small FPGA builds.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4*DEPTH aligned.
- WAIT_STATES, 0, extra cycles inserted before ack (0..15).

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  synchronous reset, active-low
- i_bus_en  input  1  transaction request; held high by initiator until ack
- i_wr_en  input  1  1 = write, 0 = read; stable while i_bus_en high
- i_addr  input  32  byte address; bits [1:0] ignored
- i_wr_data  input  32  write data
- i_byte_en  input  4  byte lane enables for writes, bit n = bits [8n+7:8n]
- o_ack  output  1  one-cycle completion pulse
- o_rd_data  output  32  read data, valid while o_ack high

Interface decision:
- One clock, `i_clk`.
- Reset `i_rst` is synchronous and active-low.

Behaviour:
- Reset (`i_rst`=0 at a rising edge):
  - state=IDLE, wait counter=0, `o_ack`=0, `o_rd_data`=0.
  - RAM contents are not cleared.
- Reset mid-transaction aborts it. No ack is issued, and a pending write is not performed.
- State machine (registered): IDLE, WAIT, ACK, RECOVER.
- IDLE:
  - On `i_bus_en`=1, capture addr/wr_en/wr_data/byte_en into internal registers.
  - Load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else ACK.
  - Inputs are not sampled again until the next IDLE.
- WAIT: counter decrements each cycle. When counter==1, go to ACK.
- Entry to ACK (same edge):
  - Write: the RAM word is updated per captured `byte_en`. Disabled lanes are unchanged. `byte_en`=0 is a legal no-op write.
  - Read: `o_rd_data` is loaded with the full RAM word; `byte_en` is ignored.
  - `o_ack` is registered high for exactly the ACK cycle.
- ACK → RECOVER unconditionally. `o_ack`=0 from the next cycle.
- RECOVER:
  - Waits for `i_bus_en`=0, then goes to IDLE.
  - An initiator holding `i_bus_en` high after ack never receives a second ack.
  - A new request is accepted only after `i_bus_en` has been seen low at least one cycle.
- Latency: request first high in IDLE at cycle N → `o_ack` high in cycle N+1+WAIT_STATES.
  - Back-to-back throughput is one transaction per WAIT_STATES+3 cycles minimum.
- `o_rd_data`:
  - Holds its last read value until the next read completes.
  - Writes do not change it.
- Address decode:
  - Word index = (`i_addr` − BASE_ADDR)[log2(DEPTH)+1:2].
  - In range iff BASE_ADDR ≤ `i_addr` < BASE_ADDR+4*DEPTH.
- Out-of-range access:
  - Still acked with normal latency, so the bus never hangs.
  - Writes are discarded; reads return 32'h0000_0000.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Changes to inputs while not in IDLE are ignored; the captured copy is used.

Optional Feature:
- Macro: `ARVI_BUS_RAM_ERR_EN`.
- When defined:
  - Adds output port `o_err` (1 bit), reset value 0.
  - `o_err` is high together with `o_ack` for out-of-range transactions, and also for a write with `byte_en` non-contiguous (e.g. 4'b0101).
  - Erroring writes are discarded. Erroring reads return 0.
- When undefined:
  - No `o_err` port.
  - Non-contiguous byte enables are written as given.
  - Out-of-range behaviour is as in Behaviour.

Test Plan:
- WAIT_STATES=0: write 32'hDEADBEEF to 0x10 with `byte_en`=4'hF, then read 0x10 → `o_ack` in cycle N+1 of each request; `o_rd_data`=32'hDEADBEEF.
- Byte lanes: word 0x20 holds 32'h11223344; write 32'hAABBCCDD with `byte_en`=4'b0010, then read → 32'h1122CC44.
- WAIT_STATES=3: read request first seen in cycle 10 → `o_ack` high only in cycle 14, one cycle wide.
- Initiator holds `i_bus_en`=1 for 6 cycles after ack → no second ack. Drop for one cycle, re-request → new ack after normal latency.
- Out-of-range read at BASE_ADDR+4*DEPTH → ack with `o_rd_data`=0.
  - With `ARVI_BUS_RAM_ERR_EN`: `o_err`=1 in the ack cycle.
  - Out-of-range write leaves word 0 unchanged.
- Assert `i_rst`=0 during WAIT of a write to 0x30 (WAIT_STATES=3) → no ack, `o_ack`/`o_rd_data`=0, word 0x30 unchanged; next request served normally.
